mips_data_mem: RTL and testbench

Parametrised data memory for the single-cycle MIPS core, the successor to the word-only data memory. Adds byte/halfword/word load-store with sign or zero extension, byte-lane writes, misalignment faults, a configurable-latency read pipeline with a valid/ready request handshake, and a reset-time clear sequencer. It sits between the datapath's load/store unit and the register-file writeback mux.

---
 rtl/mips_mem_pkg.sv | 37 +++
 rtl/mips_data_mem_if.sv | 27 ++
 rtl/mips_data_mem_lane_align.sv | 41 ++++
 rtl/mips_data_mem.sv | 111 +++++++++++
 tb/tb_mips_data_mem.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the MIPS data memory: access size and
// sequencer state encodings, byte-lane mask and alignment checks.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10,
        MEM_BAD  = 2'b11
    } mem_size_e;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } mem_state_e;

    // Byte lanes touched by an access of the given size at the given offset.
    function automatic logic [3:0] lane_mask(mem_size_e size, logic [1:0] addr_lo);
        case (size)
            MEM_BYTE: return 4'b0001 << addr_lo;
            MEM_HALF: return addr_lo[1] ? 4'b1100 : 4'b0011;
            MEM_WORD: return 4'b1111;
            default:  return 4'b0000;
        endcase
    endfunction

    // Illegal size, odd halfword or non-word-aligned word.
    function automatic logic misaligned(mem_size_e size, logic [1:0] addr_lo);
        case (size)
            MEM_BYTE: return 1'b0;
            MEM_HALF: return addr_lo[0];
            MEM_WORD: return |addr_lo;
            default:  return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mips_data_mem_if.sv
// Request/response bus between the load/store unit (master) and the data
// memory (slave). Responses have no backpressure.
interface mips_data_mem_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  rsp_valid;
    logic [31:0]           rsp_rdata;
    logic                  rsp_fault;
    logic                  busy;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault, busy
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault, busy
    );
endinterface

// File: rtl/mips_data_mem_lane_align.sv
// Combinational lane steering: picks and extends load data out of the
// addressed word, and replicates store data across lanes with a write mask.
module mem_lane_align
    import mips_mem_pkg::*;
(
    input  mem_size_e   i_size,
    input  logic        i_unsigned,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rword,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic [31:0] o_wword,
    output logic [3:0]  o_mask,
    output logic        o_fault
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Little-endian lane select, sign/zero extension and store replication.
    always_comb begin
        o_fault = misaligned(i_size, i_addr_lo);
        o_mask  = o_fault ? 4'b0000 : lane_mask(i_size, i_addr_lo);
        w_byte  = i_rword[8*i_addr_lo +: 8];
        w_half  = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];
        o_rdata = '0;
        o_wword = i_wdata;
        case (i_size)
            MEM_BYTE: begin
                o_rdata = {{24{~i_unsigned & w_byte[7]}}, w_byte};
                o_wword = {4{i_wdata[7:0]}};
            end
            MEM_HALF: begin
                o_rdata = {{16{~i_unsigned & w_half[15]}}, w_half};
                o_wword = {2{i_wdata[15:0]}};
            end
            MEM_WORD: o_rdata = i_rword;
            default:  o_rdata = '0;
        endcase
        if (o_fault) o_rdata = '0;
    end
endmodule

// File: rtl/mips_data_mem.sv
// Data memory for the single-cycle MIPS core: byte/half/word access with
// lane writes, misalignment faults, a post-reset clear sequencer and a
// fixed-latency in-order response pipeline.
module mips_data_mem
    import mips_mem_pkg::*;
#(
    parameter int ADDR_WIDTH     = 10,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input logic             clk,
    input logic             rst,
    mips_data_mem_if.slave  bus
);
    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int DEPTH = 1 << IDX_W;

    logic [31:0]             r_mem [DEPTH];
    mem_state_e              r_state, w_state_nxt;
    logic [IDX_W-1:0]        r_clr_cnt, w_clr_cnt_nxt;
    logic                    w_clr_we, w_ready, w_busy;
    logic                    w_accept, w_st_we, w_fault;
    logic [IDX_W-1:0]        w_idx;
    logic [31:0]             w_rword, w_ld_data, w_st_word, w_rsp_data;
    logic [3:0]              w_mask;
    logic [READ_LATENCY-1:0] r_vld_pipe, r_flt_pipe;
    logic [READ_LATENCY-1:0][31:0] r_data_pipe;

    assign w_idx   = bus.req_addr[ADDR_WIDTH-1:2];
    assign w_rword = r_mem[w_idx];

    mem_lane_align u_align (
        .i_size     (mem_size_e'(bus.req_size)),
        .i_unsigned (bus.req_unsigned),
        .i_addr_lo  (bus.req_addr[1:0]),
        .i_rword    (w_rword),
        .i_wdata    (bus.req_wdata),
        .o_rdata    (w_ld_data),
        .o_wword    (w_st_word),
        .o_mask     (w_mask),
        .o_fault    (w_fault)
    );

    assign w_accept   = bus.req_valid & w_ready;
    assign w_st_we    = w_accept & bus.req_write & ~w_fault;
    assign w_rsp_data = (bus.req_write | w_fault) ? 32'h0 : w_ld_data;

    // Sequencer state and clear counter; reset restarts the clear at word 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    // Clear walks every word once, then hands over to normal operation.
    // Ready is masked while rst is held so nothing is accepted in reset.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_clr_we      = 1'b0;
        w_ready       = 1'b0;
        w_busy        = 1'b0;
        case (r_state)
            CLEAR: begin
                w_clr_we = 1'b1;
                w_busy   = 1'b1;
                if (r_clr_cnt == IDX_W'(DEPTH - 1)) w_state_nxt = RUN;
                else w_clr_cnt_nxt = r_clr_cnt + 1'b1;
            end
            default: w_ready = ~rst;
        endcase
    end

    // Array writes: clear zeros, stores update only their masked lanes.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[r_clr_cnt] <= '0;
        end else if (w_st_we) begin
            for (int b = 0; b < 4; b++)
                if (w_mask[b]) r_mem[w_idx][8*b +: 8] <= w_st_word[8*b +: 8];
        end
    end

    // Response pipeline; reset drops anything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_pipe  <= '0;
            r_flt_pipe  <= '0;
            r_data_pipe <= '0;
        end else begin
            r_vld_pipe[0]  <= w_accept;
            r_flt_pipe[0]  <= w_accept & w_fault;
            r_data_pipe[0] <= w_accept ? w_rsp_data : 32'h0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_vld_pipe[i]  <= r_vld_pipe[i-1];
                r_flt_pipe[i]  <= r_flt_pipe[i-1];
                r_data_pipe[i] <= r_data_pipe[i-1];
            end
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.busy      = w_busy;
    assign bus.rsp_valid = r_vld_pipe[READ_LATENCY-1];
    assign bus.rsp_fault = r_flt_pipe[READ_LATENCY-1];
    assign bus.rsp_rdata = r_data_pipe[READ_LATENCY-1];
endmodule

// File: tb/tb_mips_data_mem.sv
// Bench for mips_data_mem: three instances (latency 1 and 3 with clear,
// latency 2 retaining contents) driven one at a time; a byte-array model
// predicts each response and per-instance monitors check data, fault and
// response latency.
module tb_mips_data_mem;
    localparam int ND = 3;
    localparam int AW = 6;
    localparam int NB = 1 << AW;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_cmp = 0;
    int n_err = 0;

    logic          req_valid [ND];
    logic          req_write [ND];
    logic          req_unsigned [ND];
    logic [1:0]    req_size [ND];
    logic [AW-1:0] req_addr [ND];
    logic [31:0]   req_wdata [ND];
    logic          req_ready [ND];
    logic          rsp_valid [ND];
    logic          rsp_fault [ND];
    logic          busy [ND];
    logic [31:0]   rsp_rdata [ND];

    byte unsigned  mb [ND][NB];
    exp_t          exp_q [ND][$];

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int LAT = (g == 1) ? 3 : (g == 2) ? 2 : 1;
        localparam int COR = (g == 2) ? 0 : 1;

        mips_data_mem_if #(.ADDR_WIDTH(AW)) bus ();

        assign bus.req_valid    = req_valid[g];
        assign bus.req_write    = req_write[g];
        assign bus.req_size     = req_size[g];
        assign bus.req_unsigned = req_unsigned[g];
        assign bus.req_addr     = req_addr[g];
        assign bus.req_wdata    = req_wdata[g];
        assign req_ready[g]     = bus.req_ready;
        assign rsp_valid[g]     = bus.rsp_valid;
        assign rsp_rdata[g]     = bus.rsp_rdata;
        assign rsp_fault[g]     = bus.rsp_fault;
        assign busy[g]          = bus.busy;

        mips_data_mem #(
            .ADDR_WIDTH(AW), .READ_LATENCY(LAT), .CLEAR_ON_RESET(COR)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        // Monitor: every presented response must match the oldest prediction.
        always @(negedge clk) begin
            exp_t e;
            if (!rst && rsp_valid[g]) begin
                n_cmp++;
                if (exp_q[g].size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_rsp dut%0d: got rdata=%h fault=%b, required no response",
                             g, rsp_rdata[g], rsp_fault[g]);
                end else begin
                    e = exp_q[g].pop_front();
                    if (rsp_rdata[g] !== e.rdata || rsp_fault[g] !== e.fault || (cyc - e.acc) != LAT - 1) begin
                        n_err++;
                        $display("FAIL rsp dut%0d: got rdata=%h fault=%b lat=%0d, required rdata=%h fault=%b lat=%0d",
                                 g, rsp_rdata[g], rsp_fault[g], cyc - e.acc + 1, e.rdata, e.fault, LAT);
                    end
                end
            end
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    // Reference: memory as a flat byte array, accesses as byte sequences.
    function automatic exp_t model(int d, bit wr, logic [1:0] sz, bit uns,
                                   logic [AW-1:0] a, logic [31:0] wd);
        exp_t e;
        int n;
        logic [31:0] v;
        e.rdata = 0; e.fault = 0; e.acc = 0;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        if (sz == 2'd3 || (int'(a) % n) != 0) begin
            e.fault = 1;
            return e;
        end
        if (wr) begin
            for (int i = 0; i < n; i++) mb[d][int'(a) + i] = wd[8*i +: 8];
        end else begin
            v = 0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = mb[d][int'(a) + i];
            if (!uns && n < 4 && v[8*n-1])
                for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
            e.rdata = v;
        end
        return e;
    endfunction

    // Drive one request, holding it until accepted (bounded), and predict it.
    // fx forces the expectation to a hand-derived constant.
    task automatic issue(int d, bit wr, logic [1:0] sz, bit uns, logic [AW-1:0] a,
                         logic [31:0] wd, bit fx = 0, logic [31:0] xr = 0, bit xf = 0);
        exp_t e;
        int t;
        req_valid[d] = 1; req_write[d] = wr; req_size[d] = sz;
        req_unsigned[d] = uns; req_addr[d] = a; req_wdata[d] = wd;
        t = 0;
        while (!req_ready[d] && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (!req_ready[d]) begin
            n_cmp++; n_err++;
            $display("FAIL accept_timeout dut%0d: got ready=0, required ready=1", d);
        end else begin
            e = model(d, wr, sz, uns, a, wd);
            if (fx) begin e.rdata = xr; e.fault = xf; end
            e.acc = cyc + 1;
            exp_q[d].push_back(e);
        end
        @(posedge clk); #1;
        req_valid[d] = 0;
    endtask

    task automatic rand_ops(int d, int n);
        logic [1:0]    sz;
        logic [AW-1:0] a;
        for (int i = 0; i < n; i++) begin
            sz = 2'($urandom_range(0, 3));
            a  = AW'($urandom_range(0, NB - 1));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                else if (sz == 2'd2) a[1:0] = 2'b00;
            end
            issue(d, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
            if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
        end
    endtask

    task automatic clear_model(int d);
        for (int i = 0; i < NB; i++) mb[d][i] = 8'h00;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        for (int d = 0; d < ND; d++) begin
            req_valid[d] = 0; req_write[d] = 0; req_size[d] = 0;
            req_unsigned[d] = 0; req_addr[d] = 0; req_wdata[d] = 0;
            clear_model(d);
        end

        // Reset values, held-reset window.
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("rst_ready_%0d", d), req_ready[d], 0);
            chk($sformatf("rst_rspv_%0d", d), rsp_valid[d], 0);
            chk($sformatf("rst_rdata_%0d", d), rsp_rdata[d], 0);
            chk($sformatf("rst_fault_%0d", d), rsp_fault[d], 0);
            chk($sformatf("rst_busy_%0d", d), busy[d], (d == 2) ? 0 : 1);
        end
        @(posedge clk); #1;
        rst = 0;

        // Clear length: busy for exactly depth cycles, retaining variant ready at once.
        cnt = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (t == 0) chk("ready_noclear_first", req_ready[2], 1);
            if (req_ready[0]) break;
            if (busy[0]) cnt++;
        end
        chk("clear_cycles", cnt, 16);
        chk("ready_after_clear", req_ready[0], 1);
        chk("busy_after_clear", busy[0], 0);
        @(posedge clk); #1;

        // Latency 1: directed lane/extension cases.
        issue(0, 0, 2'd2, 0, 6'h3C, 0, 1, 32'h00000000);
        issue(0, 1, 2'd2, 0, 6'h10, 32'h12345678);
        issue(0, 0, 2'd0, 0, 6'h11, 0, 1, 32'h00000056);
        issue(0, 0, 2'd1, 0, 6'h12, 0, 1, 32'h00001234);
        issue(0, 1, 2'd0, 0, 6'h13, 32'h000000F0);
        issue(0, 0, 2'd2, 0, 6'h10, 0, 1, 32'hF0345678);
        issue(0, 0, 2'd0, 0, 6'h13, 0, 1, 32'hFFFFFFF0);
        issue(0, 0, 2'd0, 1, 6'h13, 0, 1, 32'h000000F0);
        // Faults leave memory untouched.
        issue(0, 1, 2'd2, 0, 6'h04, 32'hA5A55A5A);
        issue(0, 0, 2'd2, 0, 6'h02, 0, 1, 32'h0, 1);
        issue(0, 1, 2'd1, 0, 6'h05, 32'h0000FFFF, 1, 32'h0, 1);
        issue(0, 1, 2'd3, 0, 6'h00, 32'hFFFFFFFF, 1, 32'h0, 1);
        issue(0, 0, 2'd2, 0, 6'h04, 0, 1, 32'hA5A55A5A);
        rand_ops(0, 200);

        // Retaining instance: initialise every word, exercise, then park a marker.
        for (int w = 0; w < NB / 4; w++) issue(2, 1, 2'd2, 0, AW'(w * 4), $urandom);
        rand_ops(2, 150);
        issue(2, 1, 2'd2, 0, 6'h20, 32'hCAFEBABE);

        // Latency 3: back-to-back loads, then random traffic.
        issue(1, 0, 2'd2, 0, 6'h00, 0);
        issue(1, 0, 2'd2, 0, 6'h04, 0);
        issue(1, 0, 2'd2, 0, 6'h08, 0);
        rand_ops(1, 200);
        repeat (5) @(posedge clk); #1;

        // Reset with two loads in flight: they must never appear.
        issue(1, 0, 2'd2, 0, 6'h10, 0);
        issue(1, 0, 2'd2, 0, 6'h14, 0);
        rst = 1;
        for (int d = 0; d < ND; d++) exp_q[d].delete();
        clear_model(0);
        clear_model(1);
        repeat (3) @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("busy_restart_1", busy[1], 1);
        chk("busy_restart_0", busy[0], 1);
        chk("ready_retain_2", req_ready[2], 1);
        @(posedge clk); #1;

        issue(2, 0, 2'd2, 0, 6'h20, 0, 1, 32'hCAFEBABE);
        // Held through the clear; answered normally once running.
        issue(0, 0, 2'd2, 0, 6'h10, 0, 1, 32'h00000000);
        rand_ops(0, 60);
        rand_ops(1, 60);
        rand_ops(2, 60);

        repeat (10) @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) chk($sformatf("drain_%0d", d), exp_q[d].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
